ufi_write_buffer: RTL and testbench
===================================

// Module: ufi_write_buffer
// PURPOSE
//  Downstream stage of the SPI master block. Buffers Ufi-bus burst writes (SPI flash -> memory
//  transfers) in a FIFO and re-issues them to the memory write port over a valid/ready handshake.
//  Absorbs memory stalls during a burst, reports end of transfer and sticky overflow to the CPU.
// PARAMETERS
//  pUfiBusWidth  16  Ufi write-data width
//  pBusAdrsBit   16  Ufi/memory address width
//  pFifoDepthBit 4   log2 FIFO depth (default 16 entries)
// PORTS
//  iSysClk     in   1                 system clock, all logic on rising edge
//  iSysRst     in   1                 asynchronous, active-low reset
//  iEn         in   1                 block enable; 0 = flush and hold idle
//  iClr        in   1                 1-cycle pulse, clears oOvf
//  iMUfiWd     in   pUfiBusWidth      Ufi write data
//  iMUfiAdrs   in   pBusAdrsBit       Ufi write address
//  iMUfiEd     in   1                 Ufi write strobe, 1 word per high cycle
//  iMUfiVd     in   1                 Ufi transfer-period valid
//  oMemWd      out  pUfiBusWidth      memory write data (FIFO head)
//  oMemAdrs    out  pBusAdrsBit       memory write address (FIFO head)
//  oMemVd      out  1                 head valid
//  iMemRdy     in   1                 memory accepts head when oMemVd & iMemRdy
//  oDone       out  1                 1-cycle pulse, burst fully written to memory
//  oOvf        out  1                 sticky: word dropped on full FIFO
//  oBusy       out  1                 state != IDLE
//  oCnt        out  pFifoDepthBit+1   FIFO occupancy
// BEHAVIOUR
//  Reset (iSysRst=0, async): FIFO pointers/count 0, state IDLE; all outputs 0.
//  FIFO: entry = {adrs,data}; push on iMUfiEd & iEn & (cnt<DEPTH | pop same cycle).
//   Pop on oMemVd & iMemRdy. oMemVd = (cnt!=0); oMemWd/oMemAdrs = head entry, registered.
//   Latency: word pushed in cycle N appears on oMem* in N+1 if FIFO was empty.
//   Push & pop same cycle: cnt unchanged, both performed (also when full).
//   Push when full without pop: word dropped, oOvf<=1 next cycle; held until iClr or reset.
//   iClr and a new overflow in the same cycle: oOvf stays 1 (set wins).
//   Pointers wrap modulo DEPTH; cnt in 0..DEPTH, never wraps.
//   iMUfiEd with iMUfiVd=0 is still pushed (Vd only drives the FSM).
//  FSM (states IDLE, ACTIVE, DRAIN):
//   IDLE   -> ACTIVE when iMUfiVd=1 & iEn=1.
//   ACTIVE -> DRAIN  when iMUfiVd=0 and (cnt!=0 or pop in flight);
//          -> IDLE   with oDone=1 when iMUfiVd=0 & FIFO empty after this cycle.
//   DRAIN  -> IDLE   with oDone=1 in the cycle after the last pop (cnt reaches 0);
//             iMUfiVd rising in DRAIN: stay in DRAIN, buffer new words, and go to ACTIVE
//             once cnt=0 (no oDone between back-to-back bursts).
//   oDone asserts in the cycle the IDLE transition is registered, for exactly 1 cycle.
//  iEn=0 (any state, next edge): FIFO flushed (cnt=0), state IDLE, oMemVd=0,
//   no oDone; oOvf is retained. Inputs are ignored while iEn=0.
//  oMemWd/oMemAdrs hold their value while oMemVd=1 & iMemRdy=0 (handshake rule).
// TESTING
//  1 Burst of 8 words adrs 0x0100..0x0107, data 0xA000+i, iMemRdy=1 -> 8 memory writes in order,
//    oMemVd first high 1 cycle after first iMUfiEd, oDone 1 pulse, oOvf=0.
//  2 iMemRdy=0 during a 20-word burst, depth 16 -> 16 stored, 4 dropped, oOvf=1, oCnt=16;
//    then iMemRdy=1 -> words 0..15 written, oDone; iClr -> oOvf=0.
//  3 FIFO full plus simultaneous push/pop each cycle -> oCnt stays 16, no drop, oOvf=0.
//  4 iMUfiVd falls with 5 words queued, iMemRdy toggled 1/0 -> state DRAIN,
//    oDone only after 5th pop.
//  5 iEn=0 mid-burst with 6 queued -> next cycle oCnt=0, oMemVd=0, oBusy=0, no oDone.
//  6 iSysRst low asynchronously mid-burst -> all outputs 0 immediately;
//    a fresh 4-word burst after release completes normally.

Source files
------------

// File: rtl/ufi_write_buffer.sv
// Ufi burst-write buffer: FIFO between the Ufi write strobe and the memory write port.
// Tracks burst activity (IDLE/ACTIVE/DRAIN) to report completion and sticky overflow.
module ufi_write_buffer #(
    parameter int pUfiBusWidth  = 16,
    parameter int pBusAdrsBit   = 16,
    parameter int pFifoDepthBit = 4
) (
    input  logic                     iSysClk,
    input  logic                     iSysRst,
    input  logic                     iEn,
    input  logic                     iClr,
    input  logic [pUfiBusWidth-1:0]  iMUfiWd,
    input  logic [pBusAdrsBit-1:0]   iMUfiAdrs,
    input  logic                     iMUfiEd,
    input  logic                     iMUfiVd,
    output logic [pUfiBusWidth-1:0]  oMemWd,
    output logic [pBusAdrsBit-1:0]   oMemAdrs,
    output logic                     oMemVd,
    input  logic                     iMemRdy,
    output logic                     oDone,
    output logic                     oOvf,
    output logic                     oBusy,
    output logic [pFifoDepthBit:0]   oCnt
);

    localparam int EW    = pBusAdrsBit + pUfiBusWidth;
    localparam int DEPTH = 1 << pFifoDepthBit;
    localparam logic [pFifoDepthBit:0] DEPTH_C = (pFifoDepthBit + 1)'(DEPTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;

    logic [EW-1:0]            mem_q [DEPTH];
    logic [pFifoDepthBit-1:0] wp_q, wp_d;
    logic [pFifoDepthBit-1:0] rp_q, rp_d;
    logic [pFifoDepthBit:0]   cnt_q, cnt_d;
    logic [1:0]               state_q, state_d;
    logic                     done_q, done_d;
    logic                     ovf_q, ovf_d;

    logic vld, full, push, pop, drop;

    assign vld  = (cnt_q != '0);
    assign full = (cnt_q == DEPTH_C);
    assign pop  = iEn & vld & iMemRdy;
    assign push = iEn & iMUfiEd & (~full | pop);
    assign drop = iEn & iMUfiEd & full & ~pop;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (!iEn) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wp_d = wp_q + 1'b1;
            if (pop)  rp_d = rp_q + 1'b1;
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Set beats clear so a drop in the clearing cycle is never lost
    assign ovf_d = drop | (ovf_q & ~(iClr & iEn));

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (!iEn) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (iMUfiVd) state_d = ACTIVE;
                end
                ACTIVE: begin
                    if (!iMUfiVd) begin
                        if (cnt_d != '0) begin
                            state_d = DRAIN;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_d == '0) begin
                        if (iMUfiVd) begin
                            state_d = ACTIVE;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge iSysClk) begin
        if (push) mem_q[wp_q] <= {iMUfiAdrs, iMUfiWd};
    end

    always_ff @(posedge iSysClk or negedge iSysRst) begin
        if (!iSysRst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    // Head is gated so an empty or reset FIFO presents zeros, not stale RAM
    assign {oMemAdrs, oMemWd} = vld ? mem_q[rp_q] : '0;
    assign oMemVd = vld;
    assign oDone  = done_q;
    assign oOvf   = ovf_q;
    assign oBusy  = (state_q != IDLE);
    assign oCnt   = cnt_q;

endmodule

// File: tb/tb_ufi_write_buffer.sv
// Scoreboard bench for ufi_write_buffer: expected memory writes queued on
// stimulus, compared as the memory port accepts them.
module tb_ufi_write_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] wd = '0;
    logic [15:0] adrs = '0;
    logic        ed = 1'b0;
    logic        vd = 1'b0;
    logic        rdy = 1'b0;
    logic [15:0] mem_wd;
    logic [15:0] mem_adrs;
    logic        mem_vd;
    logic        done;
    logic        ovf;
    logic        busy;
    logic [4:0]  cnt;

    int total = 0;
    int bad = 0;
    int n_pop = 0;
    int n_done = 0;
    int pops_at_done = -1;
    logic [31:0] sb_q [$];

    ufi_write_buffer dut (
        .iSysClk   (clk),
        .iSysRst   (rst_n),
        .iEn       (en),
        .iClr      (clr),
        .iMUfiWd   (wd),
        .iMUfiAdrs (adrs),
        .iMUfiEd   (ed),
        .iMUfiVd   (vd),
        .oMemWd    (mem_wd),
        .oMemAdrs  (mem_adrs),
        .oMemVd    (mem_vd),
        .iMemRdy   (rdy),
        .oDone     (done),
        .oOvf      (ovf),
        .oBusy     (busy),
        .oCnt      (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                n_done++;
                pops_at_done = n_pop;
            end
            if (mem_vd && rdy) begin
                n_pop++;
                if (sb_q.size() == 0)
                    chk("sb_empty", {mem_adrs, mem_wd}, 32'hxxxxxxxx);
                else
                    chk("mem", {mem_adrs, mem_wd}, sb_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input int n, input logic [15:0] a0,
                         input logic [15:0] d0, input int keep);
        for (int i = 0; i < n; i++) begin
            ed   = 1'b1;
            vd   = 1'b1;
            adrs = a0 + 16'(i);
            wd   = d0 + 16'(i);
            if (i < keep) sb_q.push_back({adrs, wd});
            step();
        end
        ed = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || cnt != 0) && n < 100) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic clr_stats();
        n_pop = 0;
        n_done = 0;
        pops_at_done = -1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_vd", 32'(mem_vd), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt", 32'(cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        step();

        // 1: 8-word burst, memory always ready
        clr_stats();
        rdy = 1'b1;
        burst(1, 16'h0100, 16'hA000, 1);
        chk("t1_lat_vd", 32'(mem_vd), 1);
        burst(7, 16'h0101, 16'hA001, 7);
        vd = 1'b0;
        wait_idle();
        step();
        chk("t1_pops", n_pop, 8);
        chk("t1_done", n_done, 1);
        chk("t1_done_at", pops_at_done, 8);
        chk("t1_ovf", 32'(ovf), 0);

        // 2: stalled 20-word burst overflows a 16-entry FIFO
        clr_stats();
        rdy = 1'b0;
        burst(20, 16'h0200, 16'hB000, 16);
        chk("t2_cnt", 32'(cnt), 16);
        chk("t2_ovf", 32'(ovf), 1);
        vd = 1'b0;
        rdy = 1'b1;
        wait_idle();
        step();
        chk("t2_pops", n_pop, 16);
        chk("t2_done", n_done, 1);
        chk("t2_ovf_held", 32'(ovf), 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t2_clr", 32'(ovf), 0);

        // 3: full FIFO with push and pop every cycle
        clr_stats();
        rdy = 1'b0;
        burst(16, 16'h0300, 16'hC000, 16);
        chk("t3_full", 32'(cnt), 16);
        rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            burst(1, 16'h0310 + 16'(k), 16'hC010 + 16'(k), 1);
            chk("t3_cnt", 32'(cnt), 16);
        end
        vd = 1'b0;
        wait_idle();
        step();
        chk("t3_pops", n_pop, 26);
        chk("t3_done", n_done, 1);
        chk("t3_ovf", 32'(ovf), 0);

        // 4: drain with a toggling ready
        clr_stats();
        rdy = 1'b0;
        burst(5, 16'h0400, 16'hD000, 5);
        vd = 1'b0;
        rdy = 1'b1;
        step();
        chk("t4_drain_busy", 32'(busy), 1);
        chk("t4_no_early", n_done, 0);
        for (int k = 0; k < 40 && (busy || cnt != 0); k++) begin
            rdy = ~rdy;
            step();
        end
        chk("t4_idle", 32'(busy), 0);
        rdy = 1'b1;
        step();
        chk("t4_pops", n_pop, 5);
        chk("t4_done", n_done, 1);
        chk("t4_done_at", pops_at_done, 5);

        // 5: disable mid-burst flushes without a done pulse
        clr_stats();
        rdy = 1'b0;
        burst(6, 16'h0500, 16'hE000, 6);
        chk("t5_cnt6", 32'(cnt), 6);
        vd = 1'b0;
        en = 1'b0;
        step();
        sb_q.delete();
        chk("t5_cnt", 32'(cnt), 0);
        chk("t5_vd", 32'(mem_vd), 0);
        chk("t5_busy", 32'(busy), 0);
        step();
        chk("t5_nodone", n_done, 0);
        en = 1'b1;
        step();

        // 6: asynchronous reset mid-burst, then a fresh burst
        rdy = 1'b0;
        burst(3, 16'h0600, 16'hF000, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_vd", 32'(mem_vd), 0);
        chk("t6_cnt", 32'(cnt), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_data", {mem_adrs, mem_wd}, 0);
        sb_q.delete();
        vd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        clr_stats();
        rdy = 1'b1;
        burst(4, 16'h0700, 16'h1000, 4);
        vd = 1'b0;
        wait_idle();
        step();
        chk("t6_pops", n_pop, 4);
        chk("t6_done", n_done, 1);
        chk("t6_sb_left", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
